// File: rtl/matrix_vector_loader.sv
// Sequences a serial N x N matrix (row-major) plus an N-element vector into per-processor row FIFOs and the vector FIFO.
// Write strobes are combinational on accept (zero latency); the selected FIFO's full flag drops rx_ready and freezes all counters.
module matrix_vector_loader #(
    parameter int P     = 4,
    parameter int DW    = 8,
    parameter int NW    = 4,
    parameter int MAX_N = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    input  logic [NW-1:0] cfg_n,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    output logic          rx_ready,
    input  logic [P-1:0]  row_full,
    input  logic          vec_full,
    output logic [P-1:0]  push_row,
    output logic          push_vec,
    output logic [DW-1:0] wr_data,
    output logic          start,
    output logic          busy,
    output logic          err_cfg
);

    localparam int TW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MATRIX = 2'd1,
        S_VECTOR = 2'd2,
        S_START  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [NW-1:0] col_q, col_d;
    logic [NW-1:0] row_q, row_d;
    logic [NW-1:0] vcnt_q, vcnt_d;
    logic [TW-1:0] tgt_q, tgt_d;
    logic          err_cfg_q, err_cfg_d;
    logic          acc;
    logic          cfg_ok;
    logic          last_col;

    assign cfg_ok   = (cfg_n != '0) && (cfg_n <= NW'(MAX_N));
    assign last_col = (col_q == n_q - 1'b1);

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_MATRIX: rx_ready = ~row_full[tgt_q];
            S_VECTOR: rx_ready = ~vec_full;
            default:  rx_ready = 1'b0;
        endcase
    end

    assign acc      = rx_valid & rx_ready;
    assign wr_data  = rx_data;
    assign push_row = (acc && state_q == S_MATRIX) ? (P'(1) << tgt_q) : '0;
    assign push_vec = acc && (state_q == S_VECTOR);
    assign start    = (state_q == S_START);
    assign busy     = (state_q != S_IDLE);
    assign err_cfg  = err_cfg_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        col_d     = col_q;
        row_d     = row_q;
        vcnt_d    = vcnt_q;
        tgt_d     = tgt_q;
        err_cfg_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_ok) begin
                        n_d     = cfg_n;
                        col_d   = '0;
                        row_d   = '0;
                        vcnt_d  = '0;
                        tgt_d   = '0;
                        state_d = S_MATRIX;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            S_MATRIX: begin
                if (acc) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        tgt_d = (tgt_q == TW'(P - 1)) ? '0 : tgt_q + 1'b1;
                        if (row_q == n_q - 1'b1) begin
                            // Last matrix element: the vector phase starts from a clean target.
                            row_d   = '0;
                            tgt_d   = '0;
                            state_d = S_VECTOR;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_VECTOR: begin
                if (acc) begin
                    if (vcnt_q == n_q - 1'b1) begin
                        vcnt_d  = '0;
                        state_d = S_START;
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end
            end
            S_START: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            vcnt_q    <= '0;
            tgt_q     <= '0;
            err_cfg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            col_q     <= col_d;
            row_q     <= row_d;
            vcnt_q    <= vcnt_d;
            tgt_q     <= tgt_d;
            err_cfg_q <= err_cfg_d;
        end
    end

endmodule

// File: tb/tb_matrix_vector_loader.sv
// Randomized bench for matrix_vector_loader: a byte-index model predicts every strobe and a scoreboard checks FIFO contents per job.
module tb_matrix_vector_loader;

    localparam int P     = 4;
    localparam int DW    = 8;
    localparam int NW    = 4;
    localparam int MAX_N = 8;

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic [NW-1:0] cfg_n;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_ready;
    logic [P-1:0]  row_full;
    logic          vec_full;
    logic [P-1:0]  push_row;
    logic          push_vec;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          err_cfg;

    int n_cmp = 0;
    int n_bad = 0;

    matrix_vector_loader #(.P(P), .DW(DW), .NW(NW), .MAX_N(MAX_N)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_n(cfg_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .row_full(row_full), .vec_full(vec_full), .push_row(push_row),
        .push_vec(push_vec), .wr_data(wr_data), .start(start), .busy(busy),
        .err_cfg(err_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_push_row"}, 32'(push_row), 32'd0);
        check({tag, "_push_vec"}, 32'(push_vec), 32'd0);
        check({tag, "_start"},    32'(start),    32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    // One complete job. Model: the k-th accepted byte belongs to matrix row k/n (FIFO (k/n)%P)
    // while k < n*n, otherwise to the vector; start follows the final accept by one cycle.
    task automatic run_job(input int n, input bit seq, input int vld_pct, input int full_pct,
                           input int stall_k, input int inj_cyc);
        logic [7:0]  bytes[$];
        logic [11:0] exp_q[$];
        logic [11:0] got_q[$];
        int total, k, cyc, stall_left, tgt, lim;
        bit ex_rdy, acc, ex_vec;
        logic [3:0] ex_row;
        total = n * n + n;
        k = 0; cyc = 0; stall_left = 4; tgt = 0;
        for (int i = 0; i < total; i++) bytes.push_back(seq ? 8'(i + 1) : 8'($urandom));
        for (int i = 0; i < total; i++)
            exp_q.push_back(i < n * n ? {4'((i / n) % P), bytes[i]} : {4'd8, bytes[i]});

        @(negedge clk);
        cfg_valid = 1'b1; cfg_n = NW'(n); rx_valid = 1'b1; rx_data = 8'hEE;
        row_full = '0; vec_full = 1'b0;
        #1;
        check("cfg_idle_rx_ready", 32'(rx_ready), 32'd0);
        check("cfg_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);

        while (k < total && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            cfg_valid = (cyc == inj_cyc);
            cfg_n     = (cyc == inj_cyc) ? 4'd7 : NW'(n);
            rx_valid  = ($urandom_range(99) < vld_pct);
            rx_data   = bytes[k];
            for (int b = 0; b < P; b++) row_full[b] = ($urandom_range(99) < full_pct);
            vec_full  = ($urandom_range(99) < full_pct);
            if (stall_k == k && stall_left > 0) begin
                row_full = 4'b0010;
                rx_valid = 1'b1;
                stall_left--;
            end
            #1;
            if (k < n * n) begin
                tgt    = (k / n) % P;
                ex_rdy = !row_full[tgt];
            end else begin
                ex_rdy = !vec_full;
            end
            acc    = rx_valid && ex_rdy;
            ex_row = (acc && k < n * n) ? 4'(1 << tgt) : 4'd0;
            ex_vec = acc && (k >= n * n);
            check("rx_ready", 32'(rx_ready), 32'(ex_rdy));
            check("push_row", 32'(push_row), 32'(ex_row));
            check("push_vec", 32'(push_vec), 32'(ex_vec));
            check("busy_job", 32'(busy), 32'd1);
            check("start_early", 32'(start), 32'd0);
            check("err_cfg_job", 32'(err_cfg), 32'd0);
            for (int b = 0; b < P; b++) if (push_row[b]) got_q.push_back({4'(b), wr_data});
            if (push_vec) got_q.push_back({4'd8, wr_data});
            if (acc) k++;
        end
        check("accepts_done", 32'(k), 32'(total));

        @(negedge clk);
        cfg_valid = 1'b0; rx_valid = 1'b1; row_full = '0; vec_full = 1'b0;
        #1;
        check("start_pulse", 32'(start), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_rx_ready", 32'(rx_ready), 32'd0);
        check("start_push_row", 32'(push_row), 32'd0);
        check("start_push_vec", 32'(push_vec), 32'd0);
        @(negedge clk);
        #1;
        check_quiet("post_job");
        rx_valid = 1'b0;

        check("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) check("sb_entry", 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic bad_cfg(input logic [NW-1:0] val);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_n = val; rx_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check("err_cfg_pulse", 32'(err_cfg), 32'd1);
        check("err_cfg_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("err_cfg_clear", 32'(err_cfg), 32'd0);
        check_quiet("err_cfg_idle");
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; cfg_n = '0; rx_valid = 1'b0; rx_data = '0;
        row_full = '0; vec_full = 1'b0;
        #1;
        check_quiet("reset");
        check("reset_err_cfg", 32'(err_cfg), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rx_valid = 1'b1;
        #1;
        check_quiet("idle_after_reset");
        rx_valid = 1'b0;

        // N=3 back-to-back, then N=5 with row 4 wrapping to FIFO 0, then N=1.
        run_job(3, 1'b1, 100, 0, -1, -1);
        run_job(5, 1'b1, 100, 0, -1, -1);
        run_job(1, 1'b1, 100, 0, -1, -1);
        // Row 1 pending while its FIFO is full for 4 cycles.
        run_job(3, 1'b1, 100, 0, 3, -1);
        // cfg_n=7 arriving mid-matrix is ignored.
        run_job(3, 1'b1, 100, 0, -1, 4);
        // Rejected sizes, then a normal small job.
        bad_cfg(4'd0);
        bad_cfg(4'd9);
        run_job(2, 1'b1, 100, 0, -1, -1);

        // Asynchronous reset after 5 matrix accepts of an N=3 job.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_n = 4'd3;
        @(negedge clk);
        cfg_valid = 1'b0; row_full = '0; vec_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i + 1);
            @(negedge clk);
        end
        rx_valid = 1'b1; rx_data = 8'h06;
        #1;
        check("pre_rst_push_row", 32'(push_row), 32'd2);
        #1;
        rst = 1'b0;
        #1;
        check_quiet("async_rst");
        check("async_rst_err_cfg", 32'(err_cfg), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            #1;
            check_quiet("idle_after_abort");
        end
        rx_valid = 1'b0;

        // Randomized jobs with random valid gaps and FIFO-full backpressure.
        for (int j = 0; j < 8; j++)
            run_job(int'($urandom_range(1, MAX_N)), 1'b0, 70, 25, -1, int'($urandom_range(1, 6)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_vector_loader.md
Name: matrix_vector_loader

Overview:
Front-end sequencer for the P03 matrix-vector engine. It takes a serial byte stream (N×N matrix row-major, then N vector elements) from the UART receive path and dispatches matrix rows round-robin into the per-processor row FIFOs. It then pushes the vector into the shared vector FIFO and issues a one-cycle start to the processor control FSM. This block owns all FIFO write-side sequencing for a job.

Parameters:
P, 4, number of processors / row FIFOs (1..8)
DW, 8, data element width in bits
NW, 4, width of the matrix-size field N
MAX_N, 8, largest accepted N (must be < 2**NW)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
cfg_valid  input  1  one-cycle strobe: new job size on cfg_n
cfg_n  input  NW  matrix dimension N for the job
rx_valid  input  1  rx_data holds a valid byte
rx_data  input  DW  incoming element
rx_ready  output  1  loader accepts rx_data this cycle
row_full  input  P  full flags of the row FIFOs
vec_full  input  1  full flag of the vector FIFO
push_row  output  P  one-hot write strobe to the row FIFOs
push_vec  output  1  write strobe to the vector FIFO
wr_data  output  DW  write data to all FIFOs
start  output  1  one-cycle pulse: job fully loaded
busy  output  1  job in progress (state != IDLE)
err_cfg  output  1  one-cycle pulse: rejected cfg_n

Behaviour:
- Reset: state=IDLE; col, row, tgt, vcnt, n_q = 0; all outputs 0. Reset mid-job aborts immediately; FIFO contents are not cleared by this block.
- Registers: n_q (latched N), col and row (0..MAX_N-1), tgt (0..P-1), vcnt (0..MAX_N-1).
- Accept condition: acc = rx_valid & rx_ready. This is the only event that advances the counters.
- wr_data = rx_data (combinational pass-through). Strobes are combinational and qualified by acc. Zero-cycle write latency.
- IDLE:
  - rx_ready=0.
  - cfg_valid with 1 <= cfg_n <= MAX_N: latch n_q=cfg_n, clear all counters, go to MATRIX.
  - cfg_valid with cfg_n=0 or cfg_n>MAX_N: err_cfg=1 on the next cycle (registered, one cycle wide); stay in IDLE.
- MATRIX:
  - rx_ready = ~row_full[tgt].
  - On acc: push_row = one-hot(tgt); col++.
  - When col==n_q-1: col wraps to 0, row++, tgt++ (tgt wraps P-1 -> 0), so row r lands in FIFO r mod P.
  - An acc at row==n_q-1 and col==n_q-1 moves to VECTOR and clears tgt.
- VECTOR:
  - rx_ready = ~vec_full.
  - On acc: push_vec=1, vcnt++.
  - An acc at vcnt==n_q-1 moves to START.
- START: start=1 for exactly one cycle (registered state decode, i.e. the cycle after the last vector accept); rx_ready=0; next state is IDLE.
- cfg_valid outside IDLE is ignored: no err_cfg, n_q unchanged.
- Backpressure: while the selected full flag is high, rx_ready=0, there is no strobe, and counters hold. A full flag on a non-selected FIFO has no effect.
- rx_valid=0 with rx_ready=1: no strobe, no state change.
- N=1: one matrix accept, then one vector accept, then START.
- At most one bit of push_row/push_vec is high in any cycle. push_row and push_vec are never high together.
- busy=1 in MATRIX, VECTOR and START.

Test Plan:
- P=4, cfg_n=3, bytes 0x01..0x0C back-to-back with no backpressure -> push_row[0] carries 01,02,03; [1] carries 04,05,06; [2] carries 07,08,09; push_vec carries 0A,0B,0C; start pulses once, 1 cycle after the 0x0C accept; busy then falls.
- P=4, cfg_n=5, 25+5 bytes -> row 4 (bytes 21..25) is written to push_row[0]; exactly 25 row strobes and 5 vec strobes; one start pulse.
- cfg_n=3, hold row_full[1]=1 for 4 cycles while row 1 is pending -> rx_ready=0 and no strobes for those cycles. Release resumes with byte 0x04 to push_row[1]; no byte is lost or duplicated.
- cfg_n=0, then cfg_n=9 (MAX_N=8) -> err_cfg pulses once for each; busy stays 0; a subsequent cfg_n=2 starts a normal job.
- cfg_valid with cfg_n=7 during MATRIX of an N=3 job -> ignored; the job completes with 9+3 accepts.
- rst low after 5 matrix accepts -> all outputs 0 asynchronously; after release, state is IDLE and rx_ready=0 until a new cfg_valid arrives.
